// File: rtl/core_next_pc.sv
// core_next_pc: next-fetch-PC generator with a direct-mapped BTB.
//
// Looks up first_half_pc in a BTB (valid/tag/target/2-bit counter per
// entry) and picks the PC for the fetch stage:
// EX redirect, else predicted-taken target, else first_half_pc4.
// The prediction is also registered in lockstep with the fetch stage's
// output register so EX can check it and train the BTB later.
//
// Ports:
//   clock, reset        clock, asynchronous active-high reset
//   stall, flush        same controls as the fetch output register
//   first_half_pc(4)    PC in fetch half 1 and that PC + 4
//   redirect_valid/pc   EX redirect (highest priority)
//   upd_valid/pc/taken/target  BTB training from a resolved branch
//   next_fetch_pc       PC for fetch to load (combinational)
//   pred_taken/target   registered prediction for the fetch bundle

// One BTB entry: storage plus its update rule.
module core_next_pc_entry #(
    parameter int TAG_W = 58
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             upd_hit,
    input  logic             upd_taken,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [63:0]      upd_target,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [63:0]      target,
    output logic [1:0]       ctr
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= 2'b01;
        end else if (wr_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr != 2'b11) ctr <= ctr + 2'd1;
                    target <= upd_target;
                end else if (ctr != 2'b00) begin
                    ctr <= ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch: evict whatever aliases here.
                valid  <= 1'b1;
                tag    <= upd_tag;
                target <= upd_target;
                ctr    <= 2'b10;
            end
        end
    end
endmodule

module core_next_pc #(
    parameter  int BTB_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] first_half_pc,
    input  logic [63:0] first_half_pc4,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_taken,
    input  logic [63:0] upd_target,
    output logic [63:0] next_fetch_pc,
    output logic        pred_taken,
    output logic [63:0] pred_target
);
    localparam int TAG_W = 62 - IDX_W;

    logic [BTB_ENTRIES-1:0]            ent_valid;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0] ent_tag;
    logic [BTB_ENTRIES-1:0][63:0]      ent_target;
    logic [BTB_ENTRIES-1:0][1:0]       ent_ctr;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, lk_taken, upd_hit;
    logic [63:0]      lk_target;

    // Byte offset within the word plays no part in indexing.
    logic unused_pc_lo;
    assign unused_pc_lo = ^{first_half_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = first_half_pc[IDX_W+1:2];
    assign lk_tag  = first_half_pc[63:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[63:IDX_W+2];

    // Lookup reads the pre-update table; a same-cycle write shows next cycle.
    assign lk_hit    = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ent_ctr[lk_idx][1];
    assign lk_target = ent_target[lk_idx];
    assign upd_hit   = ent_valid[upd_idx] && (ent_tag[upd_idx] == upd_tag);

    genvar i;
    generate
        for (i = 0; i < BTB_ENTRIES; i++) begin : g_ent
            core_next_pc_entry #(.TAG_W(TAG_W)) u_ent (
                .clock      (clock),
                .reset      (reset),
                .wr_en      (upd_valid && (upd_idx == IDX_W'(i))),
                .upd_hit    (upd_hit),
                .upd_taken  (upd_taken),
                .upd_tag    (upd_tag),
                .upd_target (upd_target),
                .valid      (ent_valid[i]),
                .tag        (ent_tag[i]),
                .target     (ent_target[i]),
                .ctr        (ent_ctr[i])
            );
        end
    endgenerate

    always_comb begin
        next_fetch_pc = first_half_pc4;
        if (redirect_valid)  next_fetch_pc = redirect_pc;
        else if (lk_taken)   next_fetch_pc = lk_target;
    end

    // Moves with the fetch output register; flush wins over stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (flush) begin
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!stall) begin
            pred_taken  <= lk_taken;
            pred_target <= lk_taken ? lk_target : 64'd0;
        end
    end
endmodule

// File: tb/tb_core_next_pc.sv
module tb_core_next_pc;
    localparam int N = 16;
    localparam int IW = 4;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic [63:0] first_half_pc, first_half_pc4;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        upd_valid, upd_taken;
    logic [63:0] upd_pc, upd_target;
    logic [63:0] next_fetch_pc;
    logic        pred_taken;
    logic [63:0] pred_target;

    core_next_pc #(.BTB_ENTRIES(N)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .first_half_pc(first_half_pc), .first_half_pc4(first_half_pc4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .next_fetch_pc(next_fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] nfp;
        logic        pt;
        logic [63:0] ptg;
    } exp_t;
    exp_t sb[$];

    // Reference model: table keyed by word index, tag is the rest of the PC.
    bit          m_valid [N];
    logic [63:0] m_tag   [N];
    logic [63:0] m_tgt   [N];
    int          m_ctr   [N];
    logic        m_pt;
    logic [63:0] m_ptg;

    int errors = 0, checks = 0;
    bit done = 0;

    function automatic int idx_of(logic [63:0] pc);
        return int'((pc >> 2) % N);
    endfunction
    function automatic logic [63:0] tag_of(logic [63:0] pc);
        return pc >> (IW + 2);
    endfunction

    // Called with inputs applied: queue expectation for this cycle,
    // then advance the model across the coming clock edge.
    task automatic step();
        exp_t e;
        int   li, ui;
        bit   hit, tk, uhit;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_ctr[k] = 1; m_tag[k] = 0; m_tgt[k] = 0;
            end
            m_pt = 0; m_ptg = 0;
        end
        li  = idx_of(first_half_pc);
        hit = m_valid[li] && m_tag[li] == tag_of(first_half_pc);
        tk  = hit && m_ctr[li] >= 2;
        e.nfp = redirect_valid ? redirect_pc : (tk ? m_tgt[li] : first_half_pc + 64'd4);
        e.pt  = m_pt;
        e.ptg = m_ptg;
        sb.push_back(e);
        if (!reset) begin
            if (flush) begin
                m_pt = 0; m_ptg = 0;
            end else if (!stall) begin
                m_pt = tk; m_ptg = tk ? m_tgt[li] : 64'd0;
            end
            if (upd_valid) begin
                ui   = idx_of(upd_pc);
                uhit = m_valid[ui] && m_tag[ui] == tag_of(upd_pc);
                if (uhit && upd_taken) begin
                    m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_tgt[ui] = upd_target;
                end else if (uhit) begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end else if (upd_taken) begin
                    m_valid[ui] = 1; m_tag[ui] = tag_of(upd_pc);
                    m_tgt[ui] = upd_target; m_ctr[ui] = 2;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input bit rv, input logic [63:0] rpc,
                         input bit uv, input logic [63:0] upc, input bit ut,
                         input logic [63:0] utg, input bit st, input bit fl, input bit rst);
        first_half_pc = pc; first_half_pc4 = pc + 64'd4;
        redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        stall = st; flush = fl; reset = rst;
        step();
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        while (!done || sb.size() != 0) begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (next_fetch_pc !== e.nfp) begin
                    errors++;
                    $display("FAIL next_fetch_pc: got %h want %h (pc=%h)", next_fetch_pc, e.nfp, first_half_pc);
                end
                checks++;
                if (pred_taken !== e.pt) begin
                    errors++;
                    $display("FAIL pred_taken: got %b want %b", pred_taken, e.pt);
                end
                checks++;
                if (pred_target !== e.ptg) begin
                    errors++;
                    $display("FAIL pred_target: got %h want %h", pred_target, e.ptg);
                end
            end
        end
    end

    initial begin
        reset = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        first_half_pc = 64'h100; first_half_pc4 = 64'h104;
        @(posedge clock); #1;
        //     pc       rv rpc     uv upc      ut utg      st fl rst
        drive(64'h100, 0, 0,      0, 0,       0, 0,       0, 0, 1);
        drive(64'h100, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h100, 0, 0,      1, 64'h120, 1, 64'h200, 0, 0, 0);
        drive(64'h120, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h100, 0, 0,      1, 64'h120, 0, 0,       0, 0, 0);
        drive(64'h100, 0, 0,      1, 64'h120, 0, 0,       0, 0, 0);
        drive(64'h120, 0, 0,      1, 64'h120, 1, 64'h200, 0, 0, 0);
        drive(64'h120, 0, 0,      1, 64'h120, 1, 64'h200, 0, 0, 0);
        drive(64'h120, 0, 0,      1, 64'h120, 1, 64'h200, 0, 0, 0);
        drive(64'h120, 0, 0,      1, 64'h120, 1, 64'h200, 0, 0, 0);
        drive(64'h120, 0, 0,      1, 64'h120, 0, 0,       0, 0, 0);
        drive(64'h120, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h160, 0, 0,      1, 64'h160, 1, 64'h300, 0, 0, 0);
        drive(64'h120, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h160, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h160, 1, 64'h400, 0, 0,      0, 0,       0, 0, 0);
        drive(64'h100, 1, 64'h400, 0, 0,      0, 0,       1, 0, 0);
        drive(64'h100, 0, 0,      0, 0,       0, 0,       1, 0, 0);
        drive(64'h160, 0, 0,      0, 0,       0, 0,       0, 1, 0);
        drive(64'h140, 0, 0,      1, 64'h140, 1, 64'h500, 0, 0, 0);
        drive(64'h140, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h140, 0, 0,      0, 0,       0, 0,       0, 0, 1);
        drive(64'h140, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        drive(64'h160, 0, 0,      0, 0,       0, 0,       0, 0, 0);
        // Random traffic over a small PC pool so hits and aliases are common.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] pc, upc, rpc, utg;
            pc  = (64'($urandom_range(0, 3)) << 32) | (64'($urandom_range(0, 63)) << 2);
            upc = (64'($urandom_range(0, 3)) << 32) | (64'($urandom_range(0, 63)) << 2);
            rpc = 64'($urandom) << 2;
            utg = {32'($urandom), 32'($urandom)};
            drive(pc, $urandom_range(0, 7) == 0, rpc,
                  $urandom_range(0, 1) == 0, upc, $urandom_range(0, 2) != 0, utg,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 60) == 0);
        end
        done = 1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
